multi_channel_sequencer: RTL and testbench

- Parametrised, time-multiplexed successor to the single-channel controller/sequencer/pitch-lookup/duration chain.
- On each beat strobe, scans NUM_CHANNELS channels in order. For each channel whose note has expired, it fetches the next pattern word from one shared pattern ROM, looks up the phase delta in one shared note ROM, and loads a per-channel beat counter.
- Drives per-channel phase delta, gate, instrument and note-on outputs to the downstream oscillators and envelopes.
- Both ROMs are external synchronous ROMs: data is valid the cycle after the address is presented.

---
 rtl/multi_channel_sequencer_pkg.sv | 32 +++
 rtl/channel_scan_fsm.sv | 91 +++++++++
 rtl/multi_channel_sequencer.sv | 121 ++++++++++++
 tb/tb_multi_channel_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_sequencer_pkg.sv
// Shared definitions for the multi-channel sequencer: pattern-word field layout,
// scan FSM state encoding and the channel-index width helper.
package multi_channel_sequencer_pkg;

  localparam int unsigned WordWidth  = 16;
  localparam int unsigned EndBit     = 15;
  localparam int unsigned PitchMsb   = 14;
  localparam int unsigned PitchLsb   = 9;
  localparam int unsigned LenMsb     = 8;
  localparam int unsigned LenLsb     = 4;
  localparam int unsigned InstrMsb   = 3;
  localparam int unsigned InstrLsb   = 0;
  localparam int unsigned PitchWidth = PitchMsb - PitchLsb + 1;
  localparam int unsigned LenWidth   = LenMsb - LenLsb + 1;
  localparam int unsigned InstrWidth = InstrMsb - InstrLsb + 1;

  localparam logic [PitchWidth-1:0] RestPitch = '0;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StPatAddr,
    StPatData,
    StNoteData,
    StNext
  } scan_state_e;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/channel_scan_fsm.sv
// Beat-driven channel scanner: walks the channels in order, sequences the
// two-stage ROM fetch and tracks one deferred strobe.
module channel_scan_fsm
  import multi_channel_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned CH_W         = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            note_stb_i,
  input  logic            remain_zero_i,
  output logic [CH_W-1:0] ch_o,
  output logic            busy_o,
  output logic            overrun_o,
  output logic            check_en_o,
  output logic            fetch_en_o,
  output logic            capture_en_o,
  output logic            commit_en_o
);

  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CHANNELS - 1);

  scan_state_e     state_q;
  logic [CH_W-1:0] ch_q;
  logic            pending_q;
  logic            overrun_q;
  logic            last_next;
  logic            stb_deferred;

  assign last_next    = (state_q == StNext) && (ch_q == LastCh);
  // Only an idle FSM with nothing pending launches a scan straight from the strobe.
  assign stb_deferred = note_stb_i && !((state_q == StIdle) && !pending_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (stb_deferred) begin
        if (pending_q) begin
          overrun_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end
      if (pending_q && ((state_q == StIdle) || last_next)) begin
        pending_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (note_stb_i || pending_q) begin
            state_q <= StCheck;
            ch_q    <= '0;
          end
        end
        StCheck:    state_q <= remain_zero_i ? StPatAddr : StNext;
        StPatAddr:  state_q <= StPatData;
        StPatData:  state_q <= StNoteData;
        StNoteData: state_q <= StNext;
        StNext: begin
          if (ch_q == LastCh) begin
            if (pending_q) begin
              state_q <= StCheck;
              ch_q    <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            ch_q    <= ch_q + CH_W'(1);
            state_q <= StCheck;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ch_o         = ch_q;
  assign busy_o       = (state_q != StIdle);
  assign overrun_o    = overrun_q;
  assign check_en_o   = (state_q == StCheck);
  assign fetch_en_o   = (state_q == StPatAddr);
  assign capture_en_o = (state_q == StPatData);
  assign commit_en_o  = (state_q == StNoteData);

endmodule

// File: rtl/multi_channel_sequencer.sv
// Time-multiplexed pattern sequencer: per-channel pointers, beat counters and
// oscillator/envelope outputs fed from shared external pattern and note ROMs.
module multi_channel_sequencer
  import multi_channel_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned PTR_WIDTH       = 6,
  parameter int unsigned NOTE_ADDR_WIDTH = 8,
  parameter int unsigned PHASE_WIDTH     = 16,
  localparam int unsigned CH_W           = ch_width(NUM_CHANNELS)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_note_stb,
  output logic [CH_W+PTR_WIDTH-1:0]         o_pat_rom_addr,
  input  logic [WordWidth-1:0]              i_pat_rom_data,
  output logic [NOTE_ADDR_WIDTH-1:0]        o_note_rom_addr,
  input  logic [PHASE_WIDTH-1:0]            i_note_rom_data,
  output logic [NUM_CHANNELS*PHASE_WIDTH-1:0] o_phase_delta,
  output logic [NUM_CHANNELS*4-1:0]         o_instrument,
  output logic [NUM_CHANNELS-1:0]           o_gate,
  output logic [NUM_CHANNELS-1:0]           o_note_on,
  output logic                              o_busy,
  output logic                              o_overrun
);

  logic [CH_W-1:0] ch;
  logic            check_en;
  logic            fetch_en;
  logic            capture_en;
  logic            commit_en;
  logic            remain_zero;

  logic [PTR_WIDTH-1:0]   ptr_q    [NUM_CHANNELS];
  logic [LenWidth-1:0]    remain_q [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] phase_q  [NUM_CHANNELS];
  logic [InstrWidth-1:0]  instr_q  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] gate_q;
  logic [NUM_CHANNELS-1:0] note_on_q;

  logic [CH_W+PTR_WIDTH-1:0]  pat_addr_q;
  logic [CH_W+PTR_WIDTH-1:0]  pat_addr_cur;
  logic [NOTE_ADDR_WIDTH-1:0] note_addr_q;
  logic [NOTE_ADDR_WIDTH-1:0] note_addr_cur;
  logic [WordWidth-1:0]       word_q;

  channel_scan_fsm #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .CH_W        (CH_W)
  ) u_scan_fsm (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .note_stb_i   (i_note_stb),
    .remain_zero_i(remain_zero),
    .ch_o         (ch),
    .busy_o       (o_busy),
    .overrun_o    (o_overrun),
    .check_en_o   (check_en),
    .fetch_en_o   (fetch_en),
    .capture_en_o (capture_en),
    .commit_en_o  (commit_en)
  );

  assign remain_zero   = (remain_q[ch] == '0);
  assign pat_addr_cur  = {ch, ptr_q[ch]};
  assign note_addr_cur = NOTE_ADDR_WIDTH'(i_pat_rom_data[PitchMsb:PitchLsb]);

  // Addresses are live only in their issuing state and otherwise hold the last value.
  assign o_pat_rom_addr  = fetch_en ? pat_addr_cur : pat_addr_q;
  assign o_note_rom_addr = capture_en ? note_addr_cur : note_addr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        ptr_q[c]    <= '0;
        remain_q[c] <= '0;
        phase_q[c]  <= '0;
        instr_q[c]  <= '0;
      end
      gate_q      <= '0;
      note_on_q   <= '0;
      pat_addr_q  <= '0;
      note_addr_q <= '0;
      word_q      <= '0;
    end else begin
      note_on_q <= '0;
      if (check_en && !remain_zero) begin
        remain_q[ch] <= remain_q[ch] - LenWidth'(1);
      end
      if (fetch_en) begin
        pat_addr_q <= pat_addr_cur;
      end
      if (capture_en) begin
        word_q      <= i_pat_rom_data;
        note_addr_q <= note_addr_cur;
      end
      if (commit_en) begin
        remain_q[ch] <= word_q[LenMsb:LenLsb];
        instr_q[ch]  <= word_q[InstrMsb:InstrLsb];
        ptr_q[ch]    <= word_q[EndBit] ? '0 : ptr_q[ch] + PTR_WIDTH'(1);
        if (word_q[PitchMsb:PitchLsb] != RestPitch) begin
          phase_q[ch]   <= i_note_rom_data;
          gate_q[ch]    <= 1'b1;
          note_on_q[ch] <= 1'b1;
        end else begin
          phase_q[ch] <= '0;
          gate_q[ch]  <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : gen_out
    assign o_phase_delta[g*PHASE_WIDTH +: PHASE_WIDTH] = phase_q[g];
    assign o_instrument[g*4 +: 4]                      = instr_q[g];
  end

  assign o_gate    = gate_q;
  assign o_note_on = note_on_q;

endmodule

// File: tb/tb_multi_channel_sequencer.sv
// Randomised scoreboard bench for multi_channel_sequencer with a beat-level
// reference model, sync ROM models and an independent output monitor.
module tb_multi_channel_sequencer;

  localparam int unsigned N   = 4;
  localparam int unsigned PW  = 2;
  localparam int unsigned NAW = 8;
  localparam int unsigned PHW = 16;
  localparam int unsigned AW  = 2 + PW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0;
  logic [AW-1:0]    pat_addr;
  logic [15:0]      pat_data = '0;
  logic [NAW-1:0]   note_addr;
  logic [PHW-1:0]   note_data = '0;
  logic [N*PHW-1:0] phase;
  logic [N*4-1:0]   instr;
  logic [N-1:0]     gate;
  logic [N-1:0]     note_on;
  logic             busy;
  logic             overrun;

  logic [15:0]    pat_rom  [2**AW];
  logic [PHW-1:0] note_rom [2**NAW];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_busy_len = 0;
  int ovr_seen = 0;
  int ch1_log[$];

  typedef struct {
    int ch; int e; logic [PHW-1:0] ph; logic [3:0] ins; logic [AW-1:0] pa; logic [NAW-1:0] na;
  } note_t;
  typedef struct {
    int s; int e; logic [N*PHW-1:0] ph; logic [N-1:0] g; logic [N*4-1:0] ins;
  } snap_t;

  note_t note_q[$];
  snap_t snap_q[$];
  int    ovr_q[$];

  // Reference model state: beats, pointers and what each channel should be showing.
  int             m_ptr[N];
  int             m_remain[N];
  logic [PHW-1:0] m_phase[N];
  logic [3:0]     m_instr[N];
  logic           m_gate[N];
  int             m_cur_end, m_pend_set, m_pend_until;

  multi_channel_sequencer #(
    .NUM_CHANNELS   (N),
    .PTR_WIDTH      (PW),
    .NOTE_ADDR_WIDTH(NAW),
    .PHASE_WIDTH    (PHW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_note_stb     (stb),
    .o_pat_rom_addr (pat_addr),
    .i_pat_rom_data (pat_data),
    .o_note_rom_addr(note_addr),
    .i_note_rom_data(note_data),
    .o_phase_delta  (phase),
    .o_instrument   (instr),
    .o_gate         (gate),
    .o_note_on      (note_on),
    .o_busy         (busy),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    pat_data  <= pat_rom[pat_addr];
    note_data <= note_rom[note_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name, input int info);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got an event (%0d) required none (cycle %0d)", name, info, cyc);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_ptr[c] = 0; m_remain[c] = 0; m_phase[c] = '0; m_instr[c] = '0; m_gate[c] = 1'b0;
    end
    m_cur_end = -1; m_pend_set = -1; m_pend_until = -1;
    note_q.delete(); snap_q.delete(); ovr_q.delete();
  endtask

  // One beat: each channel either burns a beat (2 cycles) or fetches a word (5 cycles).
  task automatic model_scan(input int s);
    int t; int start; int a; int pitch; logic [15:0] w; snap_t sn;
    start = s;
    if (s == m_cur_end && snap_q.size() > 0) begin
      start = snap_q[$].s;
      void'(snap_q.pop_back());
    end
    t = s;
    for (int c = 0; c < N; c++) begin
      if (m_remain[c] != 0) begin
        m_remain[c]--;
        t += 2;
      end else begin
        a = c * (2**PW) + m_ptr[c];
        w = pat_rom[a];
        pitch = int'(w[14:9]);
        m_remain[c] = int'(w[8:4]);
        m_instr[c] = w[3:0];
        m_ptr[c] = w[15] ? 0 : (m_ptr[c] + 1) % (2**PW);
        if (pitch != 0) begin
          m_phase[c] = note_rom[pitch];
          m_gate[c] = 1'b1;
          note_q.push_back('{c, t + 4, note_rom[pitch], w[3:0], AW'(a), NAW'(pitch)});
        end else begin
          m_phase[c] = '0;
          m_gate[c] = 1'b0;
        end
        t += 5;
      end
    end
    sn.s = start;
    sn.e = t;
    for (int c = 0; c < N; c++) begin
      sn.ph[c*PHW +: PHW] = m_phase[c];
      sn.g[c] = m_gate[c];
      sn.ins[c*4 +: 4] = m_instr[c];
    end
    snap_q.push_back(sn);
    m_cur_end = t;
  endtask

  // Strobe sampled on clock edge e.
  task automatic model_strobe(input int e);
    int s;
    if (e > m_pend_set && e <= m_pend_until) begin
      ovr_q.push_back(e);
    end else if (e <= m_cur_end) begin
      s = (e < m_cur_end) ? m_cur_end : m_cur_end + 1;
      m_pend_set = e;
      m_pend_until = s;
      model_scan(s);
    end else begin
      model_scan(e);
    end
  endtask

  task automatic tick(input bit s);
    @(posedge clk);
    #1;
    stb = s;
    if (s) model_strobe(cyc + 1);
  endtask

  task automatic drain();
    int lim;
    lim = ((m_cur_end > m_pend_until) ? m_cur_end : m_pend_until) + 3;
    tick(1'b0);
    while (cyc < lim) tick(1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"}, phase, '0);
    check({tag, "_instr"}, instr, '0);
    check({tag, "_gate"}, gate, '0);
    check({tag, "_note_on"}, note_on, '0);
    check({tag, "_busy"}, busy, '0);
    check({tag, "_overrun"}, overrun, '0);
    check({tag, "_pat_addr"}, pat_addr, '0);
    check({tag, "_note_addr"}, note_addr, '0);
  endtask

  task automatic random_rom();
    for (int a = 0; a < 2**AW; a++) begin
      pat_rom[a] = {($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                    5'($urandom_range(0, 3)), 4'($urandom)};
    end
    for (int p = 0; p < 2**NAW; p++) note_rom[p] = PHW'($urandom);
  endtask

  // Monitor: pops expectations whenever the DUT shows a note-on, end of busy or overrun.
  initial begin
    logic prev_busy;
    int busy_start;
    note_t n;
    snap_t sn;
    prev_busy = 1'b0;
    busy_start = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int c = 0; c < N; c++) begin
          if (note_on[c]) begin
            if (c == 1) ch1_log.push_back(int'(pat_addr));
            if (note_q.size() == 0) begin
              fail_event("note_on_unexpected", c);
            end else begin
              n = note_q.pop_front();
              check("note_ch", c, n.ch);
              check("note_cycle", cyc, n.e);
              check("note_phase", phase[c*PHW +: PHW], n.ph);
              check("note_instr", instr[c*4 +: 4], n.ins);
              check("note_gate", gate[c], 1'b1);
              check("note_pat_addr", pat_addr, n.pa);
              check("note_rom_addr", note_addr, n.na);
            end
          end
        end
        if (busy && !prev_busy) busy_start = cyc;
        if (!busy && prev_busy) begin
          last_busy_len = cyc - busy_start;
          if (snap_q.size() == 0) begin
            fail_event("scan_end_unexpected", cyc);
          end else begin
            sn = snap_q.pop_front();
            check("scan_start", busy_start, sn.s);
            check("scan_end", cyc, sn.e);
            check("scan_phase", phase, sn.ph);
            check("scan_gate", gate, sn.g);
            check("scan_instr", instr, sn.ins);
          end
        end
        if (overrun) begin
          ovr_seen++;
          if (ovr_q.size() == 0) fail_event("overrun_unexpected", cyc);
          else check("overrun_cycle", cyc, ovr_q.pop_front());
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ovr_before;
    int exp_wrap[5];
    exp_wrap = '{4, 5, 6, 7, 4};
    model_reset();
    for (int c = 0; c < N; c++) begin
      pat_rom[c*4 + 0] = {1'b0, 6'(c + 1), 5'd1, 4'(c)};
      pat_rom[c*4 + 1] = (c == 0) ? {1'b1, 6'd0, 5'd1, 4'd5} : {1'b0, 6'(c + 10), 5'd0, 4'd9};
      pat_rom[c*4 + 2] = {1'b0, 6'(c + 20), 5'd0, 4'd3};
      pat_rom[c*4 + 3] = {1'b0, 6'(c + 30), 5'd2, 4'd7};
    end
    for (int p = 0; p < 2**NAW; p++) note_rom[p] = PHW'(p * 100);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("post_reset");

    tick(1'b1); drain();
    check("first_gate", gate, 4'hF);
    check("first_phase", phase, {16'd400, 16'd300, 16'd200, 16'd100});
    check("first_busy_len", last_busy_len, 20);

    tick(1'b1); drain();
    check("second_busy_len", last_busy_len, 8);

    tick(1'b1); drain();
    check("rest_gate0", gate[0], 1'b0);
    check("rest_phase0", phase[15:0], 16'd0);

    tick(1'b1); drain();
    tick(1'b1); drain();

    ovr_before = ovr_seen;
    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
    drain();
    check("overrun_pulses", ovr_seen - ovr_before, 1);

    for (int r = 0; r < 2; r++) begin
      random_rom();
      for (int i = 0; i < 2000; i++) tick($urandom_range(0, 7) == 0);
      drain();
    end

    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;

    for (int a = 0; a < 2**AW; a++) pat_rom[a] = {1'b0, 6'($urandom_range(1, 63)), 5'd0, 4'($urandom)};
    ch1_log.delete();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1); drain();
    end
    check("wrap_count", ch1_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < ch1_log.size()) check("wrap_addr", ch1_log[i], exp_wrap[i]);
    end

    check("notes_left", note_q.size(), 0);
    check("scans_left", snap_q.size(), 0);
    check("overruns_left", ovr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
